// File: rtl/pi_estimator_pkg.sv
// rtl/pi_estimator_pkg.sv - shared state encoding and fixed-point constants for the pi estimator
package pi_estimator_pkg;

  localparam int PI_FRAC_BITS   = 13;
  localparam int PI_WIDTH       = 16;
  localparam int BATCH_LOG2_MIN = 2;
  localparam int BATCH_LOG2_MAX = 24;

  // 4*hits/2^B in Q3.13 equals hits * 2^(PI_FRAC_BITS+2) / 2^B
  localparam int PI_HIT_SHIFT   = PI_FRAC_BITS + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pi_state_e;

endpackage

// File: rtl/pi_fixed_scaler.sv
// rtl/pi_fixed_scaler.sv - combinational hit count to Q3.13 pi estimate, no divider
module pi_fixed_scaler
  import pi_estimator_pkg::*;
#(
  parameter int BATCH_LOG2 = 16
) (
  input  logic [BATCH_LOG2:0]   hits_i,
  output logic [PI_WIDTH-1:0]   pi_o
);

  generate
    if (BATCH_LOG2 < PI_HIT_SHIFT) begin : g_left
      assign pi_o = {hits_i, {(PI_HIT_SHIFT - BATCH_LOG2){1'b0}}};
    end else if (BATCH_LOG2 == PI_HIT_SHIFT) begin : g_pass
      assign pi_o = hits_i;
    end else begin : g_right
      // Low bits fall off: truncating right shift by BATCH_LOG2-15
      logic unused_low;
      assign pi_o       = hits_i[BATCH_LOG2 -: PI_WIDTH];
      assign unused_low = ^hits_i[BATCH_LOG2-PI_WIDTH:0];
    end
  endgenerate

endmodule

// File: rtl/pi_sample_accumulator.sv
// rtl/pi_sample_accumulator.sv - batch hit counter and pi publisher; PI_ACC_CONTINUOUS_EN restarts batches automatically
module pi_sample_accumulator
  import pi_estimator_pkg::*;
#(
  parameter int BATCH_LOG2 = 16
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  start,
  input  logic                  sampleValid,
  input  logic                  sampleInside,
  output logic                  sampleReady,
  output logic                  resultValid,
  input  logic                  resultReady,
  output logic [PI_WIDTH-1:0]   piEstimate,
  output logic [BATCH_LOG2:0]   hitCount,
  output logic                  busy,
  output logic [15:0]           batchCount
);

  pi_state_e                 state_q, state_d;
  logic [BATCH_LOG2-1:0]     sample_cnt_q, sample_cnt_d;
  logic [BATCH_LOG2:0]       hit_acc_q, hit_acc_d;
  logic [BATCH_LOG2:0]       hit_final;
  logic [PI_WIDTH-1:0]       pi_scaled;
  logic [PI_WIDTH-1:0]       pi_q;
  logic [BATCH_LOG2:0]       hit_count_q;
  logic [15:0]               batch_cnt_q;
  logic                      accept;
  logic                      last_accept;

  assign accept      = (state_q == ST_RUN) && sampleValid;
  assign last_accept = accept && (sample_cnt_q == '1);
  assign hit_final   = hit_acc_q + (BATCH_LOG2+1)'(sampleInside);

  pi_fixed_scaler #(
    .BATCH_LOG2 (BATCH_LOG2)
  ) u_scaler (
    .hits_i (hit_final),
    .pi_o   (pi_scaled)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_accept) state_d = ST_DONE;
      ST_DONE: begin
        if (resultReady) begin
`ifdef PI_ACC_CONTINUOUS_EN
          state_d = ST_RUN;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sampleReady = (state_q == ST_RUN);
    busy        = (state_q == ST_RUN);
    resultValid = (state_q == ST_DONE);
  end

  // Counters are held clear outside RUN so every entry into RUN starts a fresh batch
  always_comb begin
    sample_cnt_d = sample_cnt_q;
    hit_acc_d    = hit_acc_q;
    if (state_q != ST_RUN) begin
      sample_cnt_d = '0;
      hit_acc_d    = '0;
    end else if (accept) begin
      sample_cnt_d = sample_cnt_q + BATCH_LOG2'(1);
      hit_acc_d    = hit_final;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sample_cnt_q <= '0;
      hit_acc_q    <= '0;
      pi_q         <= '0;
      hit_count_q  <= '0;
      batch_cnt_q  <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      hit_acc_q    <= hit_acc_d;
      if (last_accept) begin
        pi_q        <= pi_scaled;
        hit_count_q <= hit_final;
        batch_cnt_q <= batch_cnt_q + 16'd1;
      end
    end
  end

  assign piEstimate = pi_q;
  assign hitCount   = hit_count_q;
  assign batchCount = batch_cnt_q;

endmodule

// File: tb/tb_pi_sample_accumulator.sv
// tb/tb_pi_sample_accumulator.sv - randomized self-checking bench for pi_sample_accumulator
module tb_pi_sample_accumulator;

  localparam int B = 4;
  localparam int N = 1 << B;

  logic        clk = 1'b0;
  logic        resetN;
  logic        start;
  logic        sampleValid;
  logic        sampleInside;
  logic        sampleReady;
  logic        resultValid;
  logic        resultReady;
  logic [15:0] piEstimate;
  logic [B:0]  hitCount;
  logic        busy;
  logic [15:0] batchCount;

  logic [17:0] hits17;
  logic [15:0] pi17;
  logic [2:0]  hits2;
  logic [15:0] pi2;

  int          checks = 0;
  int          errors = 0;
  int          model_batches = 0;
  int          model_hits = 0;
  logic [15:0] model_pi = 16'd0;

  always #5 clk = ~clk;

  pi_sample_accumulator #(.BATCH_LOG2(B)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .start        (start),
    .sampleValid  (sampleValid),
    .sampleInside (sampleInside),
    .sampleReady  (sampleReady),
    .resultValid  (resultValid),
    .resultReady  (resultReady),
    .piEstimate   (piEstimate),
    .hitCount     (hitCount),
    .busy         (busy),
    .batchCount   (batchCount)
  );

  pi_fixed_scaler #(.BATCH_LOG2(17)) u_sc17 (.hits_i(hits17), .pi_o(pi17));
  pi_fixed_scaler #(.BATCH_LOG2(2))  u_sc2  (.hits_i(hits2),  .pi_o(pi2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // pi = 4 * hits / 2^blog2 expressed in Q3.13, truncated
  function automatic logic [15:0] ref_pi(input longint hits, input int blog2);
    longint scaled;
    scaled = (hits * 4 * 8192) / (longint'(1) << blog2);
    return scaled[15:0];
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  sampleReady, 0);
    check({tag, "_rvalid"}, resultValid, 0);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_pi"},     piEstimate, 0);
    check({tag, "_hits"},   hitCount, 0);
    check({tag, "_batch"},  batchCount, 0);
  endtask

  task automatic start_batch();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ready_after_start", sampleReady, 1);
    check("busy_in_run", busy, 1);
  endtask

  task automatic feed(input int n_inside, input int n_feed, input bit rand_valid);
    bit pat[$];
    bit tmp;
    int j;
    int idx = 0;
    int cyc = 0;
    int hits = 0;
    for (int i = 0; i < N; i++) pat.push_back(i < n_inside);
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = pat[i]; pat[i] = pat[j]; pat[j] = tmp;
    end
    while (idx < n_feed && cyc < 200) begin
      sampleValid  = rand_valid ? 1'($urandom_range(1, 0)) : 1'b1;
      sampleInside = sampleValid ? pat[idx] : 1'($urandom_range(1, 0));
      if (sampleValid && sampleReady) begin
        hits += int'(pat[idx]);
        idx++;
        if (idx == N) check("rvalid_low_before_last", resultValid, 0);
      end
      @(negedge clk);
      cyc++;
    end
    sampleValid = 1'b0;
    if (idx < n_feed) check("feed_timeout", idx, n_feed);
    if (n_feed == N) begin
      model_batches = (model_batches + 1) & 16'hFFFF;
      model_hits    = hits;
      model_pi      = ref_pi(hits, B);
      check("rvalid_after_last", resultValid, 1);
      check("ready_low_in_done", sampleReady, 0);
      check("busy_low_in_done", busy, 0);
      check("hit_count", hitCount, model_hits);
      check("pi_estimate", piEstimate, model_pi);
      check("batch_count", batchCount, model_batches);
    end
  endtask

  task automatic finish_result(input int hold);
    resultReady = 1'b0;
    sampleValid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      start = (i == 0);
      sampleInside = 1'($urandom_range(1, 0));
      @(negedge clk);
      start = 1'b0;
      check("hold_rvalid", resultValid, 1);
      check("hold_ready", sampleReady, 0);
      check("hold_hits", hitCount, model_hits);
      check("hold_pi", piEstimate, model_pi);
      check("hold_batch", batchCount, model_batches);
    end
    resultReady = 1'b1;
    @(negedge clk);
    resultReady = 1'b0;
    sampleValid = 1'b0;
    check("rvalid_cleared", resultValid, 0);
`ifdef PI_ACC_CONTINUOUS_EN
    check("ready_after_handshake", sampleReady, 1);
`else
    check("ready_after_handshake", sampleReady, 0);
`endif
    check("pi_persists", piEstimate, model_pi);
    check("hits_persist", hitCount, model_hits);
  endtask

  task automatic async_reset(input string tag);
    resetN = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_batches = 0;
    model_hits    = 0;
    model_pi      = 16'd0;
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    resetN       = 1'b0;
    start        = 1'b0;
    sampleValid  = 1'b0;
    sampleInside = 1'b0;
    resultReady  = 1'b0;
    hits17       = '0;
    hits2        = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    resetN = 1'b1;

    sampleValid = 1'b1;
    @(negedge clk);
    check("idle_ignores_valid", sampleReady, 0);
    sampleValid = 1'b0;

    start_batch(); feed(12, N, 1'b0); finish_result(1);
    start_batch(); feed(16, N, 1'b0); finish_result(1);
    start_batch(); feed(0,  N, 1'b0); finish_result(1);
    start_batch(); feed(13, N, 1'b1); finish_result(5);

    start_batch(); feed(5, 7, 1'b0);
    async_reset("midbatch_reset");
    start_batch(); feed(4, N, 1'b0); finish_result(2);

    repeat (3) begin
      start_batch();
      feed($urandom_range(N, 0), N, 1'b1);
      finish_result($urandom_range(3, 1));
    end

    start_batch(); feed(9, N, 1'b0);
    async_reset("done_reset");

    hits17 = 18'd102944;
    #1;
    check("scale17_fixed", pi17, 16'h6488);
    repeat (6) begin
      hits17 = 18'($urandom_range(131072, 0));
      #1;
      check("scale17_rand", pi17, ref_pi(longint'(hits17), 17));
    end
    for (int h = 0; h <= 4; h++) begin
      hits2 = 3'(h);
      #1;
      check("scale2", pi2, ref_pi(longint'(h), 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pi_sample_accumulator.md
# pi_sample_accumulator

Downstream stage of the circle membership checker in the Pi-estimator datapath. Consumes one inside/outside verdict per accepted sample and counts hits over a fixed batch of 2^BATCH_LOG2 samples. At batch end it publishes a fixed-point estimate of pi, 4·hits/2^BATCH_LOG2, with no divider. The result is held behind a valid/ready handshake for the VGA overlay and readout logic.

## Interface
- BATCH_LOG2, default 16: log2 of samples per batch; legal range 2..24.
- clk  input  1  system clock, all logic rising-edge.
- resetN  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a batch; honoured only in IDLE.
- sampleValid  input  1  upstream verdict present this cycle.
- sampleInside  input  1  verdict, 1 = point inside circle (the checker's isInside).
- sampleReady  output  1  stage accepts a sample this cycle.
- resultValid  output  1  piEstimate/hitCount hold a completed batch.
- resultReady  input  1  consumer takes the result.
- piEstimate  output  16  unsigned Q3.13 estimate of pi.
- hitCount  output  BATCH_LOG2+1  inside count of the completed batch.
- busy  output  1  high in RUN.
- batchCount  output  16  completed batches since reset; wraps 0xFFFF→0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: sampleReady=0. start=1 → RUN; the sample counter and hit accumulator clear on the same edge.
- RUN: sampleReady=1, busy=1. A sample is accepted when sampleValid && sampleReady. Each accept increments the sample counter (BATCH_LOG2 bits) and adds sampleInside to the hit accumulator (BATCH_LOG2+1 bits).
- Last sample: accepting a sample while the counter = 2^BATCH_LOG2−1 moves the block to DONE.
  - piEstimate and hitCount are registered from the final accumulator value, including that last sample.
  - batchCount increments.
- DONE: resultValid=1, sampleReady=0. piEstimate and hitCount stay stable until resultValid && resultReady, then → IDLE.
- Scaling: piEstimate = hits << (15−BATCH_LOG2) when BATCH_LOG2 ≤ 15, otherwise hits >> (BATCH_LOG2−15) with truncation. The all-inside maximum is exactly 0x8000 (4.0), so no saturation is needed.
- start is ignored in RUN and DONE. sampleValid is ignored outside RUN.
- The published piEstimate/hitCount persist through IDLE until the next batch completes.

## Timing
- Reset values: state IDLE; sampleReady 0, resultValid 0, busy 0, piEstimate 0, hitCount 0, batchCount 0, internal counters 0.
- sampleReady rises the cycle after start is sampled in IDLE.
- Throughput: one sample per cycle, with no bubbles while sampleValid is held high.
- resultValid rises 1 cycle after the edge that accepts the last sample; sampleReady is 0 in that same cycle.
- Handshake: resultValid with resultReady high is consumed in that cycle. With PI_ACC_CONTINUOUS_EN, resultValid falls and sampleReady rises on the next cycle.
- Reset asserted mid-batch or in DONE: immediate return to reset values; any partial batch is discarded.

## Configuration
- PI_ACC_CONTINUOUS_EN defined: after the result handshake in DONE, go directly to RUN with cleared counters; start is needed only for the first batch after reset.
- Not defined: DONE always returns to IDLE, and each batch needs its own start pulse.

## Structure
- Shared package pi_estimator_pkg holds:
  - the state encoding (IDLE/RUN/DONE);
  - PI_FRAC_BITS = 13 and PI_WIDTH = 16;
  - the BATCH_LOG2 legal-range bounds.
- One sub-module, pi_fixed_scaler: combinational hits→Q3.13 shift parameterised by BATCH_LOG2.
- Counters, FSM and result registers stay in the top block.

## Test plan
- BATCH_LOG2=4, start, 16 back-to-back samples with 12 inside → resultValid 1 cycle after last accept; hitCount=12, piEstimate=0x6000 (3.0), batchCount=1.
- All 16 inside → piEstimate=0x8000. Zero inside → piEstimate=0x0000, hitCount=0.
- sampleValid toggled randomly with 13 inside → only handshaken samples counted; hitCount=13, piEstimate=0x6800.
- resultReady held low 5 cycles in DONE while sampleValid=1 → outputs stable, sampleReady=0, no samples consumed. Then resultReady=1 → IDLE, or RUN when PI_ACC_CONTINUOUS_EN is defined.
- resetN pulsed low after 7 samples → all outputs return to reset values immediately. A following batch of 16 with 4 inside → hitCount=4, piEstimate=0x2000.
- BATCH_LOG2=17 with hits=102944 → piEstimate=0x6488 (right-shift path truncates).
